// File: rtl/conversor_bcd_display.sv
// Serial double-dabble binary-to-BCD converter driving three seven-segment digits.
// Optional leading-zero blanking on the display digits when BCD_BLANK_LEADING_EN is defined.
module conversor_bcd_display #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dado,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [11:0]      bcd,
  output logic [6:0]       unidade,
  output logic [6:0]       dezena,
  output logic [6:0]       centena
);

  localparam int unsigned SR_W  = 12 + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

`ifdef BCD_BLANK_LEADING_EN
  localparam logic [6:0] RST_UPPER = SEG_BLANK;
`else
  localparam logic [6:0] RST_UPPER = SEG_ZERO;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [6:0]        unidade_q, unidade_d;
  logic [6:0]        dezena_q, dezena_d;
  logic [6:0]        centena_q, centena_d;

  logic [SR_W-1:0]   work_adj;
  logic [SR_W-1:0]   work_step;
  logic [11:0]       res_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: add-3 on nibbles >= 5, then shift left.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[WIDTH + 4*i +: 4] >= 4'd5) begin
        work_adj[WIDTH + 4*i +: 4] = work_q[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    work_step = work_adj << 1;
  end

  assign res_c = work_step[SR_W-1 -: 12];

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    unidade_d  = unidade_q;
    dezena_d   = dezena_q;
    centena_d  = centena_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (32'(dado) > 32'd999) begin
            overflow_d = 1'b1;
            bcd_d      = 12'h000;
            unidade_d  = SEG_DASH;
            dezena_d   = SEG_DASH;
            centena_d  = SEG_DASH;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
          end else begin
            work_d  = {12'h000, dado};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d     = res_c;
          unidade_d = seg7(res_c[3:0]);
          dezena_d  = seg7(res_c[7:4]);
          centena_d = seg7(res_c[11:8]);
`ifdef BCD_BLANK_LEADING_EN
          if (res_c[11:8] == 4'd0) begin
            centena_d = SEG_BLANK;
            if (res_c[7:4] == 4'd0) begin
              dezena_d = SEG_BLANK;
            end
          end
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= 12'h000;
      unidade_q  <= SEG_ZERO;
      dezena_q   <= RST_UPPER;
      centena_q  <= RST_UPPER;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
      unidade_q  <= unidade_d;
      dezena_q   <= dezena_d;
      centena_q  <= centena_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd      = bcd_q;
  assign unidade  = unidade_q;
  assign dezena   = dezena_q;
  assign centena  = centena_q;

endmodule

// File: tb/tb_conversor_bcd_display.sv
// Directed testbench for conversor_bcd_display (WIDTH=10); follows BCD_BLANK_LEADING_EN if defined.
module tb_conversor_bcd_display;

  logic       clock;
  logic       reset;
  logic       start;
  logic [9:0] dado;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [11:0] bcd;
  logic [6:0] unidade;
  logic [6:0] dezena;
  logic [6:0] centena;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int busy_cnt;

`ifdef BCD_BLANK_LEADING_EN
  localparam logic [6:0] UPPER_ZERO = 7'h00;
`else
  localparam logic [6:0] UPPER_ZERO = 7'h3F;
`endif

  conversor_bcd_display #(.WIDTH(10)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .dado    (dado),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .bcd     (bcd),
    .unidade (unidade),
    .dezena  (dezena),
    .centena (centena)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present a start strobe for one edge; returns at the negedge after E0.
  task automatic launch(input logic [9:0] v);
    start = 1'b1;
    dado  = v;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy samples and edges since E0.
  task automatic wait_done();
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    dado  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_cmp++; if (bcd !== 12'h000) begin n_err++; $display("FAIL rst_bcd: got %h want 000", bcd); end
    n_cmp++; if (unidade !== 7'h3F) begin n_err++; $display("FAIL rst_uni: got %h want 3f", unidade); end
    n_cmp++; if (dezena !== UPPER_ZERO) begin n_err++; $display("FAIL rst_dez: got %h want %h", dezena, UPPER_ZERO); end
    n_cmp++; if (centena !== UPPER_ZERO) begin n_err++; $display("FAIL rst_cen: got %h want %h", centena, UPPER_ZERO); end
  endtask

  task automatic test_convert_255();
    launch(10'd255);
    wait_done();
    n_cmp++; if (lat != 10) begin n_err++; $display("FAIL c255_latency: got %0d want 10", lat); end
    n_cmp++; if (busy_cnt != 10) begin n_err++; $display("FAIL c255_busy_cycles: got %0d want 10", busy_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL c255_busy_at_done: got %b want 0", busy); end
    n_cmp++; if (bcd !== 12'h255) begin n_err++; $display("FAIL c255_bcd: got %h want 255", bcd); end
    n_cmp++; if (centena !== 7'h5B) begin n_err++; $display("FAIL c255_cen: got %h want 5b", centena); end
    n_cmp++; if (dezena !== 7'h6D) begin n_err++; $display("FAIL c255_dez: got %h want 6d", dezena); end
    n_cmp++; if (unidade !== 7'h6D) begin n_err++; $display("FAIL c255_uni: got %h want 6d", unidade); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL c255_ovf: got %b want 0", overflow); end
    @(negedge clock);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL c255_done_width: got %b want 0", done); end
    n_cmp++; if (bcd !== 12'h255) begin n_err++; $display("FAIL c255_hold: got %h want 255", bcd); end
  endtask

  task automatic test_max_and_overflow();
    launch(10'd999);
    wait_done();
    n_cmp++; if (bcd !== 12'h999) begin n_err++; $display("FAIL c999_bcd: got %h want 999", bcd); end
    n_cmp++; if ({centena, dezena, unidade} !== {7'h6F, 7'h6F, 7'h6F})
      begin n_err++; $display("FAIL c999_segs: got %h %h %h want 6f 6f 6f", centena, dezena, unidade); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL c999_ovf: got %b want 0", overflow); end
    @(negedge clock);
    launch(10'd1000);
    wait_done();
    n_cmp++; if (lat != 0) begin n_err++; $display("FAIL ovf_latency: got %0d want 0", lat); end
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL ovf_busy: got %0d busy samples want 0", busy_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (bcd !== 12'h000) begin n_err++; $display("FAIL ovf_bcd: got %h want 000", bcd); end
    n_cmp++; if ({centena, dezena, unidade} !== {7'h40, 7'h40, 7'h40})
      begin n_err++; $display("FAIL ovf_segs: got %h %h %h want 40 40 40", centena, dezena, unidade); end
    @(negedge clock);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ovf_done_width: got %b want 0", done); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b want 1", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_small_value();
    launch(10'd7);
    wait_done();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL c7_ovf_cleared: got %b want 0", overflow); end
    n_cmp++; if (bcd !== 12'h007) begin n_err++; $display("FAIL c7_bcd: got %h want 007", bcd); end
    n_cmp++; if (centena !== UPPER_ZERO) begin n_err++; $display("FAIL c7_cen: got %h want %h", centena, UPPER_ZERO); end
    n_cmp++; if (dezena !== UPPER_ZERO) begin n_err++; $display("FAIL c7_dez: got %h want %h", dezena, UPPER_ZERO); end
    n_cmp++; if (unidade !== 7'h07) begin n_err++; $display("FAIL c7_uni: got %h want 07", unidade); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    launch(10'd123);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (lat == 2) begin start = 1'b1; dado = 10'd0; end
      else start = 1'b0;
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (lat != 10) begin n_err++; $display("FAIL ign_latency: got %0d want 10", lat); end
    n_cmp++; if (bcd !== 12'h123) begin n_err++; $display("FAIL ign_bcd: got %h want 123", bcd); end
    // Start during the done cycle must be accepted.
    launch(10'd42);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_single_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done();
    n_cmp++; if (lat != 10) begin n_err++; $display("FAIL b2b_latency: got %0d want 10", lat); end
    n_cmp++; if (bcd !== 12'h042) begin n_err++; $display("FAIL b2b_bcd: got %h want 042", bcd); end
    n_cmp++; if ({centena, dezena, unidade} !== {UPPER_ZERO, 7'h66, 7'h5B})
      begin n_err++; $display("FAIL b2b_segs: got %h %h %h want %h 66 5b", centena, dezena, unidade, UPPER_ZERO); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_shift();
    int seen_done;
    launch(10'd500);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (bcd !== 12'h000) begin n_err++; $display("FAIL mid_rst_bcd: got %h want 000", bcd); end
    n_cmp++; if ({centena, dezena, unidade} !== {UPPER_ZERO, UPPER_ZERO, 7'h3F})
      begin n_err++; $display("FAIL mid_rst_segs: got %h %h %h", centena, dezena, unidade); end
    @(negedge clock);
    reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) seen_done++;
      @(negedge clock);
    end
    n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", seen_done); end
    launch(10'd500);
    wait_done();
    n_cmp++; if (bcd !== 12'h500) begin n_err++; $display("FAIL c500_bcd: got %h want 500", bcd); end
    n_cmp++; if ({centena, dezena, unidade} !== {7'h6D, 7'h3F, 7'h3F})
      begin n_err++; $display("FAIL c500_segs: got %h %h %h want 6d 3f 3f", centena, dezena, unidade); end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    dado  = '0;
    test_reset();
    test_convert_255();
    test_max_and_overflow();
    test_small_value();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
